game_state_controller: RTL
==========================

// Module: game_state_controller
// PURPOSE
//   Owns the match sequence: drives game_state, p1_health and p2_health into the LED handler and the other game_state consumers.
//   Sequences idle -> countdown -> fight -> result -> idle using one-second ticks derived from clk.
//   Tracks player health from hit pulses and decides the winner on KO or when the round timer expires.
// PARAMETERS
//   TICKS_PER_SEC  50000000  clk cycles per second (prescaler terminal count)
//   COUNTDOWN_SEC  3         countdown length in seconds, 1..15
//   FIGHT_SEC      99        round length in seconds, 1..127
//   MAX_HEALTH     3         starting health per player, 1..7
//   RESULT_SEC     5         seconds a result state is held before returning to idle, 1..15
// PORTS
//   clk         in   1  system clock
//   rst         in   1  synchronous active-high reset
//   start       in   1  single-cycle pulse, start/skip request
//   p1_hit      in   1  single-cycle pulse, player 1 was hit
//   p2_hit      in   1  single-cycle pulse, player 2 was hit
//   game_state  out  3  0 IDLE, 1 COUNTDOWN, 2 FIGHT, 3 P1_WIN, 4 P2_WIN, 5 EQ
//   p1_health   out  3  player 1 health, 0..MAX_HEALTH
//   p2_health   out  3  player 2 health, 0..MAX_HEALTH
//   countdown   out  4  seconds left in COUNTDOWN; 0 in all other states
//   round_time  out  7  seconds left in FIGHT; holds its final value in result states
//   sec_tick    out  1  one-cycle pulse when the prescaler reaches terminal count
// BEHAVIOUR
//   - All outputs are registered. Each change appears one cycle after the input or tick that causes it.
//   - Reset values:
//       game_state = IDLE
//       p1_health = p2_health = MAX_HEALTH
//       countdown = round_time = 0, sec_tick = 0
//       prescaler = 0, result counter = 0
//   - Reset has priority over every other input and returns the block to IDLE from any state.
//   - Prescaler:
//       counts 0..TICKS_PER_SEC-1; sec_tick = 1 in the cycle it wraps.
//       It is cleared on every game_state transition, so the first second in each state is always full length.
//   - IDLE:
//       health is held at MAX_HEALTH.
//       On start: go to COUNTDOWN, countdown = COUNTDOWN_SEC.
//   - COUNTDOWN:
//       on sec_tick, countdown decrements.
//       On a tick while countdown == 1: go to FIGHT, countdown = 0, round_time = FIGHT_SEC.
//       start and hits are ignored.
//   - FIGHT:
//       p1_hit decrements p1_health and p2_hit decrements p2_health; both saturate at 0.
//       Both hits in the same cycle apply both decrements.
//       sec_tick decrements round_time.
//       Exit is evaluated on the post-update values:
//         both healths 0                  -> EQ
//         p2 health 0 only                -> P1_WIN
//         p1 health 0 only                -> P2_WIN
//         else round_time reaches 0        -> winner is the higher health; equal health -> EQ
//       A hit in the same cycle as timer expiry is applied before the comparison.
//       start is ignored.
//   - Result states (P1_WIN, P2_WIN, EQ):
//       health and round_time are frozen.
//       Go to IDLE after RESULT_SEC sec_ticks, or immediately on start.
//       On entering IDLE, health is reloaded to MAX_HEALTH on that same transition.
//   - Hits outside FIGHT are discarded; none are queued.
//   - A hit arriving in the cycle the state enters FIGHT is ignored, because the state is still COUNTDOWN in that cycle.
//   - game_state never takes the values 6 or 7. If either occurs, the next cycle forces IDLE.
// TESTING (TICKS_PER_SEC=4, COUNTDOWN_SEC=3, FIGHT_SEC=5, MAX_HEALTH=3, RESULT_SEC=2)
//   - rst, then start: COUNTDOWN with countdown=3.
//       countdown reads 2 and 1 at 4-cycle spacing; FIGHT 4 cycles later with round_time=5 and both healths 3.
//   - In FIGHT, p2_hit x3 on separate cycles: p2_health 2, 1, 0; P1_WIN the cycle after the third hit.
//       IDLE 8 cycles later with both healths 3.
//   - In FIGHT, p1_hit and p2_hit together while both healths are 1: both become 0, state EQ.
//   - In FIGHT, one p1_hit then no hits: at round_time expiry, P2_WIN (health 2 vs 3).
//       Also run a p2_hit coinciding with the expiry tick: both healths 2, result EQ.
//   - rst asserted mid-FIGHT: next cycle IDLE, healths 3, timers 0.
//       start in P1_WIN: IDLE next cycle.
//       Hits during IDLE and COUNTDOWN: no change to health.

Source files
------------

// File: rtl/game_state_controller.sv
// Match sequencer: idle -> countdown -> fight -> result -> idle, paced by a one-second prescaler.
// state      | meaning
// IDLE       | waiting for start, health held at max
// COUNTDOWN  | pre-fight countdown, hits and start ignored
// FIGHT      | hits reduce health, round timer runs
// P1/P2/EQ   | result held for RESULT_SEC seconds or until start
module game_state_controller #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int FIGHT_SEC     = 99,
    parameter int MAX_HEALTH    = 3,
    parameter int RESULT_SEC    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       p1_hit,
    input  logic       p2_hit,
    output logic [2:0] game_state,
    output logic [2:0] p1_health,
    output logic [2:0] p2_health,
    output logic [3:0] countdown,
    output logic [6:0] round_time,
    output logic       sec_tick
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_COUNTDOWN = 3'd1;
    localparam logic [2:0] ST_FIGHT     = 3'd2;
    localparam logic [2:0] ST_P1_WIN    = 3'd3;
    localparam logic [2:0] ST_P2_WIN    = 3'd4;
    localparam logic [2:0] ST_EQ        = 3'd5;

    localparam logic [2:0] HMAX = 3'(MAX_HEALTH);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    res_cnt_q, res_cnt_d;
    logic [2:0]    p1_q, p1_d, p2_q, p2_d;
    logic [3:0]    cd_q, cd_d;
    logic [6:0]    rt_q, rt_d;
    logic          tick_q;
    logic          tick_w;
    logic [2:0]    p1_dec, p2_dec;
    logic [6:0]    rt_dec;

    assign tick_w = (presc_q == PW'(TICKS_PER_SEC - 1));

    // Post-hit, post-tick fight values; exit decisions are made on these
    assign p1_dec = (p1_hit && p1_q != 3'd0) ? p1_q - 3'd1 : p1_q;
    assign p2_dec = (p2_hit && p2_q != 3'd0) ? p2_q - 3'd1 : p2_q;
    assign rt_dec = (tick_w && rt_q != 7'd0) ? rt_q - 7'd1 : rt_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_COUNTDOWN;
            ST_COUNTDOWN: if (tick_w && cd_q <= 4'd1) state_d = ST_FIGHT;
            ST_FIGHT: begin
                if (p1_dec == 3'd0 && p2_dec == 3'd0) state_d = ST_EQ;
                else if (p2_dec == 3'd0)              state_d = ST_P1_WIN;
                else if (p1_dec == 3'd0)              state_d = ST_P2_WIN;
                else if (rt_dec == 7'd0) begin
                    if (p1_dec > p2_dec)      state_d = ST_P1_WIN;
                    else if (p2_dec > p1_dec) state_d = ST_P2_WIN;
                    else                      state_d = ST_EQ;
                end
            end
            ST_P1_WIN, ST_P2_WIN, ST_EQ:
                if (start || (tick_w && res_cnt_q == 4'(RESULT_SEC - 1))) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_d   = tick_w ? '0 : presc_q + 1'b1;
        res_cnt_d = res_cnt_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        cd_d      = cd_q;
        rt_d      = rt_q;
        case (state_q)
            ST_IDLE: begin
                p1_d = HMAX;
                p2_d = HMAX;
                cd_d = start ? 4'(COUNTDOWN_SEC) : 4'd0;
            end
            ST_COUNTDOWN: begin
                if (tick_w) cd_d = cd_q - 4'd1;
                if (state_d == ST_FIGHT) begin
                    cd_d = 4'd0;
                    rt_d = 7'(FIGHT_SEC);
                end
            end
            ST_FIGHT: begin
                p1_d = p1_dec;
                p2_d = p2_dec;
                rt_d = rt_dec;
            end
            ST_P1_WIN, ST_P2_WIN, ST_EQ: begin
                if (tick_w) res_cnt_d = res_cnt_q + 4'd1;
                if (state_d == ST_IDLE) begin
                    p1_d = HMAX;
                    p2_d = HMAX;
                    rt_d = 7'd0;
                end
            end
            default: begin
                p1_d = HMAX;
                p2_d = HMAX;
                cd_d = 4'd0;
                rt_d = 7'd0;
            end
        endcase
        // Every state starts with a full-length first second
        if (state_d != state_q) begin
            presc_d   = '0;
            res_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            res_cnt_q <= 4'd0;
            p1_q      <= HMAX;
            p2_q      <= HMAX;
            cd_q      <= 4'd0;
            rt_q      <= 7'd0;
            tick_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            res_cnt_q <= res_cnt_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            cd_q      <= cd_d;
            rt_q      <= rt_d;
            tick_q    <= tick_w;
        end
    end

    assign game_state = state_q;
    assign p1_health  = p1_q;
    assign p2_health  = p2_q;
    assign countdown  = cd_q;
    assign round_time = rt_q;
    assign sec_tick   = tick_q;
endmodule
